// File: rtl/qu_uop_queue.sv
// Multi-lane circular uop FIFO between rename and dispatch.
// Up to ENQ_WIDTH uops are written per cycle and the DEQ_WIDTH oldest entries
// are shown every cycle. Payloads are opaque and are returned bit-exact.

package qu_uop;
    localparam int UOP_WIDTH = 67;
    typedef logic [UOP_WIDTH-1:0] uop_t;
endpackage

// One dequeue lane. It raises valid when the queue holds more than LANE
// entries, and it forces the payload to zero when the lane is invalid.
module qu_deq_lane #(
    parameter int UOP_WIDTH = 67,
    parameter int CW        = 4,
    parameter int LANE      = 0
) (
    input  logic [CW-1:0]        count,
    input  logic [UOP_WIDTH-1:0] entry,
    output logic                 valid,
    output logic [UOP_WIDTH-1:0] uop
);
    // Lane i holds the i-th oldest entry only if that many entries exist
    always_comb begin
        valid = (count > CW'(LANE));
        uop   = valid ? entry : '0;
    end
endmodule

module qu_uop_queue #(
    parameter int UOP_WIDTH = qu_uop::UOP_WIDTH,
    parameter int DEPTH     = 8,
    parameter int ENQ_WIDTH = 2,
    parameter int DEQ_WIDTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [ENQ_WIDTH-1:0]           enq_valid,
    input  logic [ENQ_WIDTH*UOP_WIDTH-1:0] enq_uop,
    output logic                           enq_ready,
    output logic [DEQ_WIDTH-1:0]           deq_valid,
    output logic [DEQ_WIDTH*UOP_WIDTH-1:0] deq_uop,
    input  logic [DEQ_WIDTH-1:0]           deq_ready,
    output logic [$clog2(DEPTH):0]         count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ENQW_C  = CW'(ENQ_WIDTH);

    logic [UOP_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;
    logic [CW-1:0]        n_enq;
    logic [CW-1:0]        n_enq_eff;
    logic [CW-1:0]        n_deq;
    logic [DEQ_WIDTH-1:0][UOP_WIDTH-1:0] lane_entry;
    logic [DEQ_WIDTH-1:0][UOP_WIDTH-1:0] lane_uop;

    // The ready signal uses only the registered count. It is computed before any
    // dequeue in this cycle, so a full queue refuses a group even while draining.
    assign enq_ready = ((DEPTH_C - count) >= ENQW_C);

    // Enqueue group size is the run of set valid bits that starts at lane 0
    always_comb begin
        logic run;
        n_enq = '0;
        run   = 1'b1;
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            if (run && enq_valid[i]) n_enq = n_enq + 1'b1;
            else                     run   = 1'b0;
        end
        n_enq_eff = enq_ready ? n_enq : '0;
    end

    // Dequeue count is the run of valid&ready lanes that starts at lane 0
    always_comb begin
        logic run;
        n_deq = '0;
        run   = 1'b1;
        for (int i = 0; i < DEQ_WIDTH; i++) begin
            if (run && deq_valid[i] && deq_ready[i]) n_deq = n_deq + 1'b1;
            else                                     run   = 1'b0;
        end
    end

    // Per-lane read view. The head offset wraps modulo DEPTH through the pointer width.
    for (genvar i = 0; i < DEQ_WIDTH; i++) begin : g_deq
        assign lane_entry[i] = mem[head + PW'(i)];

        qu_deq_lane #(
            .UOP_WIDTH (UOP_WIDTH),
            .CW        (CW),
            .LANE      (i)
        ) u_lane (
            .count (count),
            .entry (lane_entry[i]),
            .valid (deq_valid[i]),
            .uop   (lane_uop[i])
        );

        assign deq_uop[i*UOP_WIDTH +: UOP_WIDTH] = lane_uop[i];
    end

    // Storage write. Valid masking on the read side hides stale data, so storage is never cleared.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            for (int k = 0; k < ENQ_WIDTH; k++) begin
                if (CW'(k) < n_enq_eff)
                    mem[tail + PW'(k)] <= enq_uop[k*UOP_WIDTH +: UOP_WIDTH];
            end
        end
    end

    // Pointer and occupancy update. Reset has priority over flush, and flush has priority over handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(n_deq);
            tail  <= tail + PW'(n_enq_eff);
            count <= count + n_enq_eff - n_deq;
        end
    end

    // Occupancy must stay within the storage size
    always_ff @(posedge clk) begin
        if (!rst) assert (count <= DEPTH_C);
    end
endmodule
